rank_order_spike_tx: RTL
========================

// Module: rank_order_spike_tx
// PURPOSE
//  Rank-order spike transmitter: consumer of the sorter's encoded image (pixel indexes sorted by decreasing intensity).
//  Snapshots the index list on start, then emits one AER event per rank, address = pixel index, on a 4-phase req/ack link.
//  Sits between the sorter and the neuron core's AER input; busy/done let the control FSM sequence the next image.
// PARAMETERS
//  IMAGE_SIZE       5                      pixels per image = length of index list
//  IMAGE_SIZE_BITS  $clog2(IMAGE_SIZE)     width of one pixel index / AER address
//  N_SPIKES         IMAGE_SIZE             ranks emitted per image, 1..IMAGE_SIZE; ranks >= N_SPIKES are dropped
//  SPIKE_GAP        0                      idle cycles inserted between consecutive events, 0..255
// PORTS
//  CLK             in   1                                   clock, rising edge
//  RST_N           in   1                                   asynchronous, active-low reset
//  sorted_indexes  in   [IMAGE_SIZE_BITS-1:0] [0:IMAGE_SIZE-1]   rank-ordered pixel indexes, entry 0 = brightest
//  start           in   1                                   pulse; sampled only in IDLE (driven by sorter done)
//  abort           in   1                                   pulse; end transmission after current handshake
//  aer_addr        out  IMAGE_SIZE_BITS                     event address, stable while aer_req=1
//  aer_req         out  1                                   4-phase request
//  aer_ack         in   1                                   4-phase acknowledge from core
//  busy            out  1                                   high from start acceptance until DONE exits
//  done            out  1                                   one-cycle pulse when transmission ends
// BEHAVIOUR
//  Reset: state=IDLE, aer_req=0, aer_addr=0, busy=0, done=0, rank=0, gap counter=0, abort_pend=0, buffer=0. All outputs registered.
//  IDLE    : start=1 -> on that edge: buffer<=sorted_indexes, rank<=0, aer_addr<=sorted_indexes[0], aer_req<=1, busy<=1; -> SEND.
//  SEND    : hold req/addr; ack_s=1 -> aer_req<=0; -> RELEASE.
//  RELEASE : wait ack_s=0. Then if rank==N_SPIKES-1 or abort_pend -> DONE;
//            else if SPIKE_GAP==0 -> rank++, aer_addr<=buffer[rank+1], aer_req<=1, -> SEND;
//            else gap_cnt<=SPIKE_GAP-1, -> GAP.
//  GAP     : aer_req=0; abort_pend -> DONE; gap_cnt==0 -> rank++, load addr, aer_req<=1, -> SEND; else gap_cnt--.
//  DONE    : done=1, busy=0 on exit; -> IDLE. Next start accepted no earlier than the cycle after DONE.
//  Latency: start edge -> aer_req visible next cycle; ack_s rise -> req fall 1 edge; ack_s fall -> next req rise 1 edge (gap 0).
//  Ordering: events leave strictly in rank order 0..N_SPIKES-1; exactly N_SPIKES req pulses unless aborted.
//  Snapshot: sorted_indexes may change at any time after the start edge without affecting the current transmission.
//  start while busy (incl. DONE cycle): ignored, no buffer update.
//  abort: sets abort_pend (sticky until IDLE); never truncates a live handshake (req high waits for ack);
//         abort in IDLE ignored; abort same edge as start: start wins, abort ignored.
//  Index values are sent unchecked (values >= IMAGE_SIZE passed through).
//  Reset mid-handshake: aer_req drops immediately (async); core must tolerate a dangling ack.
//  rank width IMAGE_SIZE_BITS+1; no wrap since rank stops at N_SPIKES-1.
// CONFIGURATION
//  AER_ACK_SYNC_EN defined: aer_ack passed through 2-flop synchronizer -> ack_s; each ack edge seen 2 cycles later.
//  AER_ACK_SYNC_EN undefined: ack_s = aer_ack directly (core in same clock domain); latencies as above.
// STRUCTURE
//  Shared package snn_aer_pkg: tx_state_t enum {IDLE,SEND,RELEASE,GAP,DONE}, AER handshake phase constants.
//  Sub-module sync_2ff (1-bit, async active-low reset to 0), instantiated only under AER_ACK_SYNC_EN.
//  Remainder in one module: FSM, rank counter, gap counter, snapshot buffer, output registers.
// TESTING (IMAGE_SIZE=5, sorted_indexes={3,1,4,0,2}, ack responder: rise 1 cycle after req, fall 1 cycle after req fall)
//  Full frame, gap 0: start pulse -> addrs 3,1,4,0,2 in order, 5 req pulses, one done pulse, busy low after.
//  N_SPIKES=2 -> only addrs 3,1 emitted, then done; ranks 2..4 never appear.
//  SPIKE_GAP=3 -> exactly 3 cycles + 1 between ack_s fall and next req rise, for every inter-event interval.
//  Change sorted_indexes to {0,0,0,0,0} and re-pulse start 1 cycle after first start -> still 3,1,4,0,2; second start ignored.
//  abort pulsed while rank 1 req high -> rank 1 handshake completes, done next, 2 events total.
//  RST_N low while req high -> aer_req=0 same cycle, all outputs at reset values; fresh start -> full frame from rank 0.

Source files
------------

// File: rtl/snn_aer_pkg.sv
// Shared types and AER handshake constants for the spike transmit path.
package snn_aer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RELEASE,
    GAP,
    DONE
  } tx_state_t;

  localparam int   GAP_BITS   = 8;
  localparam logic REQ_IDLE   = 1'b0;
  localparam logic REQ_ACTIVE = 1'b1;
  localparam logic ACK_LOW    = 1'b0;
  localparam logic ACK_HIGH   = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the AER acknowledge; only built when AER_ACK_SYNC_EN is defined.
`ifdef AER_ACK_SYNC_EN
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule
`endif

// File: rtl/rank_order_spike_tx.sv
// Rank-order spike transmitter: snapshots the sorted index list and emits one 4-phase AER event per rank.
// Define AER_ACK_SYNC_EN when aer_ack comes from another clock domain.
module rank_order_spike_tx
  import snn_aer_pkg::*;
#(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int N_SPIKES        = IMAGE_SIZE,
  parameter int SPIKE_GAP       = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [IMAGE_SIZE_BITS-1:0] sorted_indexes [0:IMAGE_SIZE-1],
  input  logic                       start,
  input  logic                       abort,
  output logic [IMAGE_SIZE_BITS-1:0] aer_addr,
  output logic                       aer_req,
  input  logic                       aer_ack,
  output logic                       busy,
  output logic                       done
);

  localparam logic [IMAGE_SIZE_BITS:0] LAST_RANK = (IMAGE_SIZE_BITS+1)'(N_SPIKES - 1);
  localparam logic [GAP_BITS-1:0]      GAP_LOAD  = GAP_BITS'(SPIKE_GAP - 1);

  logic ack_s;

`ifdef AER_ACK_SYNC_EN
  sync_2ff u_ack_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (aer_ack),
    .q     (ack_s)
  );
`else
  assign ack_s = aer_ack;
`endif

  tx_state_t                  state_q, state_d;
  logic [IMAGE_SIZE_BITS:0]   rank_q, rank_d, next_rank;
  logic [GAP_BITS-1:0]        gap_q, gap_d;
  logic                       abort_pend_q, abort_pend_d;
  logic [IMAGE_SIZE_BITS-1:0] buf_q [0:IMAGE_SIZE-1];
  logic [IMAGE_SIZE_BITS-1:0] buf_d [0:IMAGE_SIZE-1];
  logic [IMAGE_SIZE_BITS-1:0] addr_q, addr_d;
  logic                       req_q, req_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       advance;

  always_comb begin
    state_d      = state_q;
    rank_d       = rank_q;
    gap_d        = gap_q;
    abort_pend_d = abort_pend_q;
    buf_d        = buf_q;
    addr_d       = addr_q;
    req_d        = req_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    advance      = 1'b0;
    next_rank    = rank_q + 1'b1;

    // Abort only latches while a frame is in flight; it never cuts a live handshake.
    if (state_q != IDLE && abort) begin
      abort_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          buf_d        = sorted_indexes;
          rank_d       = '0;
          addr_d       = sorted_indexes[0];
          req_d        = REQ_ACTIVE;
          busy_d       = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (ack_s == ACK_HIGH) begin
          req_d   = REQ_IDLE;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (ack_s == ACK_LOW) begin
          if (rank_q == LAST_RANK || abort_pend_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (SPIKE_GAP == 0) begin
            advance = 1'b1;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (abort_pend_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (gap_q == '0) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE: begin
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      rank_d  = next_rank;
      addr_d  = buf_q[next_rank[IMAGE_SIZE_BITS-1:0]];
      req_d   = REQ_ACTIVE;
      state_d = SEND;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      rank_q       <= '0;
      gap_q        <= '0;
      abort_pend_q <= 1'b0;
      buf_q        <= '{default: '0};
      addr_q       <= '0;
      req_q        <= REQ_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rank_q       <= rank_d;
      gap_q        <= gap_d;
      abort_pend_q <= abort_pend_d;
      buf_q        <= buf_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign aer_addr = addr_q;
  assign aer_req  = req_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
